// File: rtl/regmst_ext_timeout_bridge_if.sv
// Request/response bundle between the register master, the timeout bridge and one external slave.
// The slave modport is the bridge's view; the master modport is the surrounding environment's view.
interface regmst_ext_timeout_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned ERR_CNT_W = 8;

  // upstream request / response
  logic                    up_req_vld;
  logic                    up_wr_en;
  logic                    up_rd_en;
  logic [ADDR_WIDTH-1:0]   up_addr;
  logic [DATA_WIDTH-1:0]   up_wr_data;
  logic                    up_ack_vld;
  logic [DATA_WIDTH-1:0]   up_rd_data;

  // downstream request / response
  logic                    dn_req_vld;
  logic                    dn_wr_en;
  logic                    dn_rd_en;
  logic [ADDR_WIDTH-1:0]   dn_addr;
  logic [DATA_WIDTH-1:0]   dn_wr_data;
  logic                    dn_ack_vld;
  logic [DATA_WIDTH-1:0]   dn_rd_data;

  // error reporting
  logic                    timeout_err;
  logic                    proto_err;
  logic [ERR_CNT_W-1:0]    err_cnt;
  logic                    err_cnt_clr;

  modport slave (
    input  up_req_vld, up_wr_en, up_rd_en, up_addr, up_wr_data,
    input  dn_ack_vld, dn_rd_data,
    input  err_cnt_clr,
    output up_ack_vld, up_rd_data,
    output dn_req_vld, dn_wr_en, dn_rd_en, dn_addr, dn_wr_data,
    output timeout_err, proto_err, err_cnt
  );

  modport master (
    output up_req_vld, up_wr_en, up_rd_en, up_addr, up_wr_data,
    output dn_ack_vld, dn_rd_data,
    output err_cnt_clr,
    input  up_ack_vld, up_rd_data,
    input  dn_req_vld, dn_wr_en, dn_rd_en, dn_addr, dn_wr_data,
    input  timeout_err, proto_err, err_cnt
  );

endinterface

// File: rtl/regmst_ext_timeout_bridge.sv
// Register-master to external-slave bridge that closes unanswered requests with an error response.
// Optional saturating error counter enabled by REGMST_EXT_BRIDGE_ERR_CNT_EN.
module regmst_ext_timeout_bridge #(
  parameter int unsigned            ADDR_WIDTH     = 64,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0]  TIMEOUT_RDATA  = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  regmst_ext_timeout_bridge_if.slave bus
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  // request classification: exactly one of wr/rd is a legal request
  logic                    req_ok_c;
  logic                    req_bad_c;
  logic                    cnt_last_c;

  assign req_ok_c   = bus.up_req_vld & (bus.up_wr_en ^ bus.up_rd_en);
  assign req_bad_c  = bus.up_req_vld & ~(bus.up_wr_en ^ bus.up_rd_en);
  assign cnt_last_c = (cnt_q == CNT_LAST);

  // next values of the registered outputs
  logic                    accept_d;
  logic                    ack_vld_d;
  logic [DATA_WIDTH-1:0]   rd_data_d;
  logic                    timeout_err_d;
  logic                    proto_err_d;

  // output registers
  logic                    up_ack_vld_q;
  logic [DATA_WIDTH-1:0]   up_rd_data_q;
  logic                    dn_req_vld_q;
  logic                    dn_wr_en_q;
  logic                    dn_rd_en_q;
  logic [ADDR_WIDTH-1:0]   dn_addr_q;
  logic [DATA_WIDTH-1:0]   dn_wr_data_q;
  logic                    timeout_err_q;
  logic                    proto_err_q;

  // state register and wait-cycle counter
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic; the counter cannot wrap because WAIT exits at CNT_LAST
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_ok_c) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (req_bad_c) begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (bus.dn_ack_vld || cnt_last_c) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // output logic; an ack seen together with the last wait cycle wins over the timeout
  always_comb begin
    accept_d      = 1'b0;
    ack_vld_d     = 1'b0;
    rd_data_d     = '0;
    timeout_err_d = 1'b0;
    proto_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_ok_c) begin
          accept_d = 1'b1;
        end else if (req_bad_c) begin
          ack_vld_d   = 1'b1;
          rd_data_d   = TIMEOUT_RDATA;
          proto_err_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.dn_ack_vld) begin
          ack_vld_d = 1'b1;
          rd_data_d = dn_rd_en_q ? bus.dn_rd_data : '0;
        end else if (cnt_last_c) begin
          ack_vld_d     = 1'b1;
          rd_data_d     = TIMEOUT_RDATA;
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        ack_vld_d = 1'b0;
      end
    endcase
  end

  // response and error pulses
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      up_ack_vld_q  <= 1'b0;
      up_rd_data_q  <= '0;
      dn_req_vld_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      up_ack_vld_q  <= ack_vld_d;
      up_rd_data_q  <= rd_data_d;
      dn_req_vld_q  <= accept_d;
      timeout_err_q <= timeout_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // downstream request fields hold until the next accepted request
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      dn_wr_en_q   <= 1'b0;
      dn_rd_en_q   <= 1'b0;
      dn_addr_q    <= '0;
      dn_wr_data_q <= '0;
    end else if (accept_d) begin
      dn_wr_en_q   <= bus.up_wr_en;
      dn_rd_en_q   <= bus.up_rd_en;
      dn_addr_q    <= bus.up_addr;
      dn_wr_data_q <= bus.up_wr_data;
    end
  end

  assign bus.up_ack_vld  = up_ack_vld_q;
  assign bus.up_rd_data  = up_rd_data_q;
  assign bus.dn_req_vld  = dn_req_vld_q;
  assign bus.dn_wr_en    = dn_wr_en_q;
  assign bus.dn_rd_en    = dn_rd_en_q;
  assign bus.dn_addr     = dn_addr_q;
  assign bus.dn_wr_data  = dn_wr_data_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.proto_err   = proto_err_q;

`ifdef REGMST_EXT_BRIDGE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 err_inc_c;

  assign err_inc_c = timeout_err_d | proto_err_d;

  // counts in step with the error pulse; clear beats a same-cycle increment
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      err_cnt_q <= '0;
    end else if (bus.err_cnt_clr) begin
      err_cnt_q <= '0;
    end else if (err_inc_c && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic err_cnt_clr_unused;

  assign err_cnt_clr_unused = bus.err_cnt_clr;
  assign bus.err_cnt        = '0;
`endif

endmodule

// File: tb/tb_regmst_ext_timeout_bridge.sv
// Directed bench for regmst_ext_timeout_bridge: vector table plus hand-written reset and saturation sequences.
module tb_regmst_ext_timeout_bridge;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
  localparam int NVEC = 8;
  localparam int WIN  = 25;

`ifdef REGMST_EXT_BRIDGE_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic        rd;
    logic [63:0] addr;
    logic [31:0] wdata;
    int          ack_dly;    // ack driven in cycle T+1+ack_dly, -1 for none
    logic [31:0] ack_data;
    int          late;       // extra stray ack cycle relative to T, -1 for none
    bit          hold;       // keep up_req_vld high until the response
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_to;
    bit          exp_pr;
  } vec_t;

  logic PCLK;
  logic PRESETn;

  regmst_ext_timeout_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regmst_ext_timeout_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_RDATA  (TO_DATA)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int model_err = 0;
  logic        last_wr = 1'b0;
  logic        last_rd = 1'b0;
  logic [63:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [63:0] exp_cnt();
    return CNT_EN ? 64'(model_err) : 64'd0;
  endfunction

  task automatic bump_err();
    if (model_err < 255) model_err++;
  endtask

  task automatic check_dn(input string tag);
    check({tag, " dn_wr_en"},   64'(bus.dn_wr_en),   64'(last_wr));
    check({tag, " dn_rd_en"},   64'(bus.dn_rd_en),   64'(last_rd));
    check({tag, " dn_addr"},    bus.dn_addr,         last_addr);
    check({tag, " dn_wr_data"}, 64'(bus.dn_wr_data), 64'(last_wdata));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " up_ack_vld"},  64'(bus.up_ack_vld),  64'd0);
    check({tag, " up_rd_data"},  64'(bus.up_rd_data),  64'd0);
    check({tag, " dn_req_vld"},  64'(bus.dn_req_vld),  64'd0);
    check({tag, " dn_ctrl"},     64'({bus.dn_wr_en, bus.dn_rd_en}), 64'd0);
    check({tag, " dn_addr"},     bus.dn_addr,          64'd0);
    check({tag, " dn_wr_data"},  64'(bus.dn_wr_data),  64'd0);
    check({tag, " err_pulses"},  64'({bus.timeout_err, bus.proto_err}), 64'd0);
    check({tag, " err_cnt"},     64'(bus.err_cnt),     64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          ack_cnt;
    int          ack_at;
    int          req_cnt;
    int          req_at;
    bit          stray;
    logic [31:0] got_data;
    bit          got_to;
    bit          got_pr;
    bit          fwd;
    fwd      = v.wr ^ v.rd;
    ack_cnt  = 0;
    ack_at   = -1;
    req_cnt  = 0;
    req_at   = -1;
    stray    = 1'b0;
    got_data = '0;
    got_to   = 1'b0;
    got_pr   = 1'b0;
    if (fwd) begin
      last_wr    = v.wr;
      last_rd    = v.rd;
      last_addr  = v.addr;
      last_wdata = v.wdata;
    end
    bus.up_req_vld = 1'b1;
    bus.up_wr_en   = v.wr;
    bus.up_rd_en   = v.rd;
    bus.up_addr    = v.addr;
    bus.up_wr_data = v.wdata;
    bus.dn_rd_data = v.ack_data;
    for (int c = 1; c <= WIN; c++) begin
      step();
      if (bus.dn_req_vld) begin
        req_cnt++;
        req_at = c;
      end
      if (bus.up_ack_vld) begin
        ack_cnt++;
        if (ack_cnt == 1) begin
          ack_at   = c;
          got_data = bus.up_rd_data;
          got_to   = bus.timeout_err;
          got_pr   = bus.proto_err;
        end
      end else if (bus.up_rd_data != '0 || bus.timeout_err || bus.proto_err) begin
        stray = 1'b1;
      end
      if (c == 1) check_dn({tag, " c1"});
      if (!v.hold || bus.up_ack_vld) bus.up_req_vld = 1'b0;
      if (bus.up_ack_vld) begin
        bus.up_wr_en = 1'b0;
        bus.up_rd_en = 1'b0;
      end
      bus.dn_ack_vld = (v.ack_dly >= 0 && c == v.ack_dly + 1) || (c == v.late);
    end
    bus.dn_ack_vld = 1'b0;
    if (v.exp_to || v.exp_pr) bump_err();
    check({tag, " dn_req_cnt"},  64'(req_cnt), fwd ? 64'd1 : 64'd0);
    if (fwd) check({tag, " dn_req_at"}, 64'(req_at), 64'd1);
    check({tag, " ack_cnt"},     64'(ack_cnt), 64'd1);
    check({tag, " ack_lat"},     64'(ack_at), 64'(v.exp_lat));
    check({tag, " rd_data"},     64'(got_data), 64'(v.exp_rdata));
    check({tag, " timeout_err"}, 64'(got_to), 64'(v.exp_to));
    check({tag, " proto_err"},   64'(got_pr), 64'(v.exp_pr));
    check({tag, " idle_quiet"},  64'(stray), 64'd0);
    check_dn({tag, " end"});
    check({tag, " err_cnt"},     64'(bus.err_cnt), exp_cnt());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;

    vecs[0] = '{wr:1'b0, rd:1'b1, addr:64'h40, wdata:32'h0, ack_dly:3, ack_data:32'h1234_5678,
                late:-1, hold:1'b0, exp_lat:5, exp_rdata:32'h1234_5678, exp_to:1'b0, exp_pr:1'b0};
    vecs[1] = '{wr:1'b1, rd:1'b0, addr:64'h1000_0000_0000_0008, wdata:32'hA5A5_A5A5, ack_dly:0,
                ack_data:32'h1111_2222, late:-1, hold:1'b0, exp_lat:2, exp_rdata:32'h0, exp_to:1'b0, exp_pr:1'b0};
    vecs[2] = '{wr:1'b0, rd:1'b1, addr:64'h80, wdata:32'h0, ack_dly:-1, ack_data:32'h3333_4444,
                late:20, hold:1'b0, exp_lat:17, exp_rdata:TO_DATA, exp_to:1'b1, exp_pr:1'b0};
    vecs[3] = '{wr:1'b0, rd:1'b1, addr:64'hC4, wdata:32'h0, ack_dly:15, ack_data:32'hCAFE_F00D,
                late:-1, hold:1'b1, exp_lat:17, exp_rdata:32'hCAFE_F00D, exp_to:1'b0, exp_pr:1'b0};
    vecs[4] = '{wr:1'b1, rd:1'b1, addr:64'hFFF0, wdata:32'h77, ack_dly:-1, ack_data:32'h0,
                late:-1, hold:1'b0, exp_lat:1, exp_rdata:TO_DATA, exp_to:1'b0, exp_pr:1'b1};
    vecs[5] = '{wr:1'b0, rd:1'b0, addr:64'h1234, wdata:32'h0, ack_dly:2, ack_data:32'h5555_6666,
                late:-1, hold:1'b0, exp_lat:1, exp_rdata:TO_DATA, exp_to:1'b0, exp_pr:1'b1};
    vecs[6] = '{wr:1'b1, rd:1'b0, addr:64'h8, wdata:32'h5A5A_5A5A, ack_dly:14, ack_data:32'h9999_8888,
                late:-1, hold:1'b1, exp_lat:16, exp_rdata:32'h0, exp_to:1'b0, exp_pr:1'b0};
    vecs[7] = '{wr:1'b0, rd:1'b1, addr:64'hFFFF_FFFF_FFFF_FFFC, wdata:32'h0, ack_dly:1, ack_data:32'h0000_0001,
                late:-1, hold:1'b0, exp_lat:3, exp_rdata:32'h0000_0001, exp_to:1'b0, exp_pr:1'b0};

    PRESETn         = 1'b0;
    bus.up_req_vld  = 1'b0;
    bus.up_wr_en    = 1'b0;
    bus.up_rd_en    = 1'b0;
    bus.up_addr     = '0;
    bus.up_wr_data  = '0;
    bus.dn_ack_vld  = 1'b0;
    bus.dn_rd_data  = '0;
    bus.err_cnt_clr = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    PRESETn = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // back-to-back illegal requests drive the counter into saturation
    n_ack = 0;
    for (int i = 0; i < 300; i++) begin
      bus.up_req_vld = 1'b1;
      bus.up_wr_en   = 1'b1;
      bus.up_rd_en   = 1'b1;
      step();
      if (bus.up_ack_vld && bus.proto_err && bus.up_rd_data == TO_DATA) n_ack++;
      bus.up_req_vld = 1'b0;
      bus.up_wr_en   = 1'b0;
      bus.up_rd_en   = 1'b0;
      bump_err();
      step();
    end
    check("sat proto responses", 64'(n_ack), 64'd300);
    check("sat err_cnt", 64'(bus.err_cnt), exp_cnt());

    // clear in the same cycle as an illegal request: the clear wins
    bus.up_req_vld  = 1'b1;
    bus.err_cnt_clr = 1'b1;
    step();
    check("clr proto_err", 64'(bus.proto_err), 64'd1);
    check("clr err_cnt", 64'(bus.err_cnt), 64'd0);
    bus.up_req_vld  = 1'b0;
    bus.err_cnt_clr = 1'b0;
    model_err = 0;
    step();
    check("clr err_cnt hold", 64'(bus.err_cnt), 64'd0);
    bus.up_req_vld = 1'b1;
    step();
    bus.up_req_vld = 1'b0;
    bump_err();
    check("post clr err_cnt", 64'(bus.err_cnt), exp_cnt());
    step();

    // reset during WAIT abandons the transaction; a later ack is dropped
    bus.up_req_vld = 1'b1;
    bus.up_rd_en   = 1'b1;
    bus.up_addr    = 64'h200;
    step();
    check("rst dn_req_vld", 64'(bus.dn_req_vld), 64'd1);
    bus.up_req_vld = 1'b0;
    step();
    step();
    PRESETn      = 1'b0;
    bus.up_rd_en = 1'b0;
    step();
    check_all_zero("mid_reset");
    model_err  = 0;
    last_wr    = 1'b0;
    last_rd    = 1'b0;
    last_addr  = '0;
    last_wdata = '0;
    PRESETn = 1'b1;
    bus.dn_ack_vld = 1'b1;
    bus.dn_rd_data = 32'h7777_7777;
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      bus.dn_ack_vld = 1'b0;
      if (bus.up_ack_vld) n_ack++;
    end
    check("rst no ack", 64'(n_ack), 64'd0);
    check_all_zero("after_reset");
    run_vec(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
